// File: rtl/mmcm_drp_responder.sv
// mmcm_drp_responder: behavioural MMCM DRP slave with a 128x16 register file and a LOCKED model
// Ports: clk_usb/reset_i clock and sync active-high reset; drp_addr/den/dwe/din request;
// drp_dout/drdy response; drp_reset MMCM RST; mmcm_locked modelled LOCKED; drp_err sticky error.
// Define MMCM_DRP_LOCK_MODEL_EN to model the RST-to-LOCKED delay; otherwise LOCKED follows ~RST.
module mmcm_drp_responder #(
  parameter int pDRDY_LATENCY = 4,
  parameter int pLOCK_CYCLES  = 64
) (
  input  logic        clk_usb,
  input  logic        reset_i,
  input  logic [6:0]  drp_addr,
  input  logic        drp_den,
  input  logic        drp_dwe,
  input  logic [15:0] drp_din,
  output logic [15:0] drp_dout,
  output logic        drp_drdy,
  input  logic        drp_reset,
  output logic        mmcm_locked,
  output logic        drp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        dwe_q, dwe_d, err_q, err_d, accept;
  logic [15:0] din_q, din_d, dout_q, dout_d;
  logic [15:0] mem_q [128];
  always_comb begin
    accept  = state_q == IDLE && drp_den;
    addr_d  = accept ? drp_addr : addr_q;
    dwe_d   = accept ? drp_dwe : dwe_q;
    din_d   = accept ? drp_din : din_q;
    cnt_d   = accept ? 4'(pDRDY_LATENCY - 1) : state_q == BUSY ? cnt_q - 4'd1 : cnt_q;
    // DONE is entered on the edge where the counter would reach zero, so DRDY lands exactly pDRDY_LATENCY cycles after DEN
    state_d = state_q == DONE ? IDLE :
              state_q == BUSY ? (cnt_q <= 4'd1 ? DONE : BUSY) :
              accept ? (pDRDY_LATENCY == 1 ? DONE : BUSY) : IDLE;
    // read data is registered on entry to DONE so it is valid alongside DRDY
    dout_d  = (state_d == DONE && !dwe_d) ? mem_q[addr_d] : dout_q;
    err_d   = err_q | (drp_den && state_q != IDLE) | (accept && drp_dwe && !drp_reset);
  end
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dwe_q   <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 128; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dwe_q   <= dwe_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      if (state_q == DONE && dwe_q) mem_q[addr_q] <= din_q;
    end
  end
  assign drp_drdy = state_q == DONE;
  assign drp_dout = dout_q;
  assign drp_err  = err_q;
`ifdef MMCM_DRP_LOCK_MODEL_EN
  logic [15:0] lock_q, lock_d;
  // saturates at pLOCK_CYCLES so LOCKED stays high until RST
  always_comb lock_d = drp_reset ? '0 : lock_q == 16'(pLOCK_CYCLES) ? lock_q : lock_q + 16'd1;
  always_ff @(posedge clk_usb) begin
    if (reset_i) lock_q <= '0;
    else lock_q <= lock_d;
  end
  assign mmcm_locked = !reset_i && !drp_reset && lock_q == 16'(pLOCK_CYCLES);
`else
  assign mmcm_locked = !reset_i && !drp_reset;
`endif
endmodule

// File: tb/tb_mmcm_drp_responder.sv
// tb_mmcm_drp_responder: directed checks of DRP latency, data path, error flag and LOCKED behaviour
module tb_mmcm_drp_responder;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic        den0 = 1'b0, den1 = 1'b0, dwe0 = 1'b0, dwe1 = 1'b0;
  logic [15:0] din0 = '0, din1 = '0, dout0, dout1;
  logic        drdy0, drdy1, drp_reset = 1'b1, drp_reset1 = 1'b1;
  logic        locked0, locked1, err0, err1;
  int          checks = 0, failures = 0, n0 = 0;
  logic [15:0] rd;
  int          lat, base, rise;

  always #5 clk = ~clk;

  mmcm_drp_responder u_dut (
    .clk_usb(clk), .reset_i(reset_i), .drp_addr(addr0), .drp_den(den0), .drp_dwe(dwe0),
    .drp_din(din0), .drp_dout(dout0), .drp_drdy(drdy0), .drp_reset(drp_reset),
    .mmcm_locked(locked0), .drp_err(err0));

  mmcm_drp_responder #(.pDRDY_LATENCY(1)) u_dut1 (
    .clk_usb(clk), .reset_i(reset_i), .drp_addr(addr1), .drp_den(den1), .drp_dwe(dwe1),
    .drp_din(din1), .drp_dout(dout1), .drp_drdy(drdy1), .drp_reset(drp_reset1),
    .mmcm_locked(locked1), .drp_err(err1));

  always @(negedge clk) if (drdy0) n0 <= n0 + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns one negedge after DRDY so the DUT is idle again
  task automatic xact(input bit d1, input bit we, input logic [6:0] a, input logic [15:0] d,
                      output logic [15:0] r, output int l);
    r = '0;
    l = 0;
    if (d1) begin den1 = 1'b1; dwe1 = we; addr1 = a; din1 = d; end
    else begin den0 = 1'b1; dwe0 = we; addr0 = a; din0 = d; end
    for (int n = 1; n <= 20 && l == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin den0 = 1'b0; den1 = 1'b0; end
      if (d1 ? drdy1 : drdy0) begin
        l = n;
        r = d1 ? dout1 : dout0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_drdy", drdy0, 0);
    check("rst_dout", dout0, 16'h0000);
    check("rst_err", err0, 0);
    check("rst_locked", locked0, 0);
    reset_i = 1'b0;
    @(negedge clk);
    xact(0, 1, 7'h08, 16'h1249, rd, lat);
    check("wr_lat", lat, 4);
    xact(0, 0, 7'h08, 16'h0000, rd, lat);
    check("rd_lat", lat, 4);
    check("rd_data", rd, 16'h1249);
    check("rd_err", err0, 0);
    xact(0, 1, 7'h09, 16'h5555, rd, lat);
    check("wr_keeps_dout", dout0, 16'h1249);
    xact(1, 0, 7'h33, 16'h0000, rd, lat);
    check("l1_rd_lat", lat, 1);
    check("l1_rd_data", rd, 16'h0000);
    xact(1, 1, 7'h22, 16'hABCD, rd, lat);
    xact(1, 0, 7'h22, 16'h0000, rd, lat);
    check("l1_wr_rd_lat", lat, 1);
    check("l1_wr_rd_data", rd, 16'hABCD);
    check("l1_err", err1, 0);
    base = n0;
    den0 = 1'b1; dwe0 = 1'b0; addr0 = 7'h08;
    @(negedge clk) den0 = 1'b0;
    @(negedge clk) begin den0 = 1'b1; addr0 = 7'h09; end
    @(negedge clk) den0 = 1'b0;
    repeat (8) @(negedge clk);
    check("ovl_one_drdy", n0 - base, 1);
    check("ovl_data", dout0, 16'h1249);
    check("ovl_err", err0, 1);
    xact(0, 0, 7'h09, 16'h0000, rd, lat);
    check("ovl_next_data", rd, 16'h5555);
    check("err_sticky", err0, 1);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("err_cleared", err0, 0);
    check("dout_cleared", dout0, 16'h0000);
    base = n0;
    den0 = 1'b1; dwe0 = 1'b1; addr0 = 7'h10; din0 = 16'hBEEF;
    @(negedge clk) begin den0 = 1'b0; reset_i = 1'b1; end
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_drdy", n0 - base, 0);
    xact(0, 0, 7'h10, 16'h0000, rd, lat);
    check("abort_no_commit", rd, 16'h0000);
    xact(0, 0, 7'h09, 16'h0000, rd, lat);
    check("mem_cleared", rd, 16'h0000);
`ifdef MMCM_DRP_LOCK_MODEL_EN
    check("lock_held", locked0, 0);
    drp_reset = 1'b0;
    rise = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (locked0 && rise < 0) rise = k;
    end
    check("lock_rise", rise, 64);
    check("lock_stay", locked0, 1);
    drp_reset = 1'b1;
    #1 check("lock_force", locked0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lock_pulse", locked0, 0);
    end
    drp_reset = 1'b0;
    repeat (30) @(negedge clk);
    drp_reset = 1'b1;
    @(negedge clk) drp_reset = 1'b0;
    rise = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (locked0 && rise < 0) rise = k;
    end
    check("lock_restart", rise, 64);
`else
    for (int k = 0; k < 8; k++) begin
      drp_reset = (8'b1011_0010 >> k) & 8'd1;
      #1 check("lock_follow", locked0, !drp_reset);
      @(negedge clk);
      check("lock_follow_cyc", locked0, !drp_reset);
    end
`endif
    drp_reset = 1'b0;
    @(negedge clk);
    xact(0, 1, 7'h20, 16'h7777, rd, lat);
    check("wr_norst_err", err0, 1);
    drp_reset = 1'b1;
    xact(0, 0, 7'h20, 16'h0000, rd, lat);
    check("sim_lat", lat, 4);
    check("sim_data", rd, 16'h7777);
    check("sim_locked", locked0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmcm_drp_responder.md
MMCM_DRP_RESPONDER -- requirements
Module: mmcm_drp_responder

Interface
- REQ-001 The block SHALL have parameter pDRDY_LATENCY, default 4, giving DEN-to-DRDY cycles (legal 1..15).
- REQ-002 The block SHALL have parameter pLOCK_CYCLES, default 64, giving cycles from RST release to LOCKED (legal 1..65535).
- REQ-003 The block SHALL have one clock and a synchronous, active-high reset, exactly as follows: clk_usb  input  1  sole clock; reset_i  input  1  synchronous active-high reset.
- REQ-004 The block SHALL have these ports:
  - drp_addr  input  7  DRP register address.
  - drp_den  input  1  DRP enable, one-cycle strobe.
  - drp_dwe  input  1  write enable, qualified by drp_den.
  - drp_din  input  16  write data.
  - drp_dout  output  16  read data.
  - drp_drdy  output  1  transaction-complete pulse.
  - drp_reset  input  1  MMCM RST.
  - mmcm_locked  output  1  modelled LOCKED.
  - drp_err  output  1  sticky protocol-violation flag.

Function
- REQ-005 The block SHALL hold a 128 x 16 register array addressed by drp_addr.
- REQ-006 The FSM SHALL have states IDLE, BUSY and DONE.
- REQ-007 In IDLE, drp_den=1 SHALL capture addr, dwe and din, load the latency counter with pDRDY_LATENCY-1 and enter BUSY; with pDRDY_LATENCY=1 it SHALL enter DONE directly.
- REQ-008 BUSY SHALL decrement the counter each cycle and enter DONE when the counter reaches 0.
- REQ-009 DONE SHALL last one cycle with drp_drdy=1, then return to IDLE.
- REQ-010 drp_drdy SHALL be high exactly pDRDY_LATENCY cycles after the cycle in which drp_den was sampled.
- REQ-011 A write SHALL commit to the array in the DONE cycle, using the captured address and data.
- REQ-012 A read SHALL drive drp_dout with the array word in the DONE cycle.
- REQ-013 drp_dout SHALL hold its value until the next read completes; a write SHALL leave drp_dout unchanged.
- REQ-014 drp_den=1 while in BUSY or DONE SHALL be ignored (captured fields unchanged) and SHALL set drp_err.
- REQ-015 A write captured while drp_reset=0 SHALL still commit and SHALL set drp_err.
- REQ-016 drp_err SHALL remain set until reset_i.
- REQ-017 drp_reset=1 SHALL force mmcm_locked=0 and clear the lock counter in the same cycle; DRP transactions SHALL proceed normally during drp_reset.
- REQ-018 After drp_reset falls, the lock counter SHALL increment each cycle.
- REQ-019 mmcm_locked SHALL rise on the cycle the lock counter equals pLOCK_CYCLES and then stay high; the counter SHALL saturate and never wrap.
- REQ-020 drp_reset reasserted mid-count SHALL restart the lock count from 0.
- REQ-021 Simultaneous drp_den and drp_reset rising SHALL both take effect in the same cycle, independently.

Reset
- REQ-022 reset_i=1 SHALL clear every array word to 16'h0000.
- REQ-023 reset_i=1 SHALL set the FSM to IDLE, drp_drdy=0, drp_dout=16'h0000, drp_err=0, mmcm_locked=0 and clear both counters.
- REQ-024 reset_i asserted during BUSY or DONE SHALL abort the transaction with no write commit and no drp_drdy pulse.
- REQ-025 After reset_i falls with drp_reset=0, the lock count SHALL start at the first cycle out of reset.

Configuration
- REQ-026 With macro MMCM_DRP_LOCK_MODEL_EN defined, the lock model of REQ-017 to REQ-020 SHALL be compiled in.
- REQ-027 Without MMCM_DRP_LOCK_MODEL_EN, the lock counter SHALL be absent.
- REQ-028 Without MMCM_DRP_LOCK_MODEL_EN, mmcm_locked SHALL equal ~drp_reset, except that it SHALL be 0 while reset_i=1.
- REQ-029 All other behaviour SHALL be identical with or without MMCM_DRP_LOCK_MODEL_EN.

Verification
- REQ-030 Write/read: with drp_reset=1, write addr 0x08 data 16'h1249, then read 0x08 -> each drp_drdy exactly 4 cycles after its DEN, drp_dout=16'h1249, drp_err=0.
- REQ-031 Latency edge: pDRDY_LATENCY=1, read of an unwritten address -> drp_drdy on the next cycle, drp_dout=16'h0000.
- REQ-032 Overlap: second DEN 2 cycles after the first (latency 4) -> exactly one drp_drdy, first transaction's data returned, drp_err=1 and sticky.
- REQ-033 Lock: pulse drp_reset for 3 cycles -> mmcm_locked=0 during the pulse, rises 64 cycles after the fall; reasserting drp_reset at count 30 -> the 64-cycle count restarts.
- REQ-034 Reset mid-op: reset_i in cycle 2 of a write to 0x10 data 16'hBEEF -> no drp_drdy; a subsequent read of 0x10 returns 16'h0000.
- REQ-035 Config: build without MMCM_DRP_LOCK_MODEL_EN, toggle drp_reset -> mmcm_locked equals ~drp_reset every cycle.
